// File: rtl/eka_imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
// The responder FSM, its wait counter and the idle instruction word live here.
package eka_imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-clock instruction storage: one write port, one read port.
// Read data is registered and only updates on a read strobe.
module imem_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Both updates are non-blocking, so a same-index read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: accepts word addresses, returns
// instruction words after WAIT_STATES cycles, one request in flight.
//
// Handshakes: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; a response transfers on an edge where rsp_valid
// and rsp_ready are both high. rsp_valid, rsp_instr and rsp_err stay stable
// until that transfer, unless flush or reset discards the response.
module imem_responder
    import eka_imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-3:0] BASE_ADDR = '0,
    localparam int IDX_W = $clog2(DEPTH_WORDS),
    localparam int WA = ADDR_WIDTH - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [WA-1:0]    req_addr,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic             rsp_err,
    input  logic             flush,
    output logic             stall,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [31:0]      load_data,
    output state_e           dbg_state
);

    localparam logic [WA:0] DEPTH_EXT = (WA + 1)'(DEPTH_WORDS);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [WA-1:0]    offset;
    logic             in_range;
    logic             accept;
    logic [31:0]      ram_rdata;

    // Range check runs on the full-width offset; truncation to an index comes after.
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        in_range = (req_addr >= BASE_ADDR) && ({1'b0, offset} < DEPTH_EXT);
    end

    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            req_ready = flush || (state == IDLE) || (state == RESP && rsp_ready);
        end
    end

    assign accept = req_valid && req_ready;

    assign stall = (state == WAIT)
                 | (state == RESP && !rsp_ready)
                 | (state == IDLE && req_valid);

    imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (load_en),
        .waddr(load_addr),
        .wdata(load_data),
        .re   (accept && in_range),
        .raddr(offset[IDX_W-1:0]),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
        end else if (accept) begin
            // Covers IDLE, back-to-back in RESP and a flush redirect alike.
            err_q <= !in_range;
            if (WAIT_STATES == 0) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
            end else begin
                state     <= WAIT;
                cnt       <= CNT_W'(WAIT_STATES);
                rsp_valid <= 1'b0;
            end
        end else if (flush) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM read register holds its word until the next accepted read.
    assign rsp_instr = (rsp_valid && !err_q) ? ram_rdata : NOP;
    assign rsp_err   = rsp_valid && err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: preload, latency, back-to-back,
// range error, hold, flush redirect, read-first load and reset abort.
module tb_imem_responder;
    import eka_imem_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [29:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        stall;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    state_e      dbg_state;

    int n_checks = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prog[4];

    imem_responder #(
        .ADDR_WIDTH(32),
        .DEPTH_WORDS(1024),
        .WAIT_STATES(1),
        .BASE_ADDR(30'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_err(rsp_err),
        .flush(flush),
        .stall(stall),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Driver: present a request for one edge, then drop req_valid.
    task automatic send_req(input logic [29:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108113;
        prog[2] = 32'h002081b3;
        prog[3] = 32'h0000006f;

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        tick(); tick(); tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_instr", rsp_instr, NOP);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 10'(i); load_data = prog[i];
            tick();
        end
        load_en = 1'b0;

        // First fetch: accepted at T, stall T..T+1, response at T+2.
        req_valid = 1'b1; req_addr = 30'd0;
        #1;
        check("t1_stall_accept", 32'(stall), 32'd1);
        tick();
        req_valid = 1'b0;
        check("t1_stall_wait", 32'(stall), 32'd1);
        check("t1_ready_wait", 32'(req_ready), 32'd0);
        check("t1_valid_wait", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_instr", rsp_instr, prog[0]);
        check("t1_err", 32'(rsp_err), 32'd0);

        // Back-to-back: rsp_ready and req_valid held high across addrs 1..3.
        for (int a = 1; a < 4; a++) exp_q.push_back(prog[a]);
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int a = 1; a < 4; a++) begin
            req_addr = 30'(a);
            #1;
            check("b2b_ready", 32'(req_ready), 32'd1);
            tick();
            check("b2b_gap", 32'(rsp_valid), 32'd0);
            tick();
            check("b2b_valid", 32'(rsp_valid), 32'd1);
            if (exp_q.size() == 0) check("b2b_queue", 32'd1, 32'd0);
            else check("b2b_instr", rsp_instr, exp_q.pop_front());
        end
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        check("b2b_drain", 32'(rsp_valid), 32'd0);

        // Out of range.
        send_req(30'h400);
        tick();
        check("oor_valid", 32'(rsp_valid), 32'd1);
        check("oor_err", 32'(rsp_err), 32'd1);
        check("oor_instr", rsp_instr, NOP);
        consume();
        check("oor_err_clear", 32'(rsp_err), 32'd0);

        // Hold in RESP with rsp_ready low.
        send_req(30'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_instr", rsp_instr, prog[1]);
            check("hold_stall", 32'(stall), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        consume();
        check("hold_release", 32'(rsp_valid), 32'd0);

        // Flush in WAIT with a redirect to addr 2.
        send_req(30'd0);
        flush = 1'b1; req_valid = 1'b1; req_addr = 30'd2;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_old_gone", 32'(rsp_valid), 32'd0);
        tick();
        check("flush_valid", 32'(rsp_valid), 32'd1);
        check("flush_instr", rsp_instr, prog[2]);
        consume();

        // Same-cycle write and read of index 0 returns the old word.
        load_en = 1'b1; load_addr = 10'd0; load_data = 32'hdeadbeef;
        send_req(30'd0);
        load_en = 1'b0;
        tick();
        check("rf_old", rsp_instr, prog[0]);
        consume();
        send_req(30'd0);
        tick();
        check("rf_new", rsp_instr, 32'hdeadbeef);
        consume();

        // Write to the latched index during WAIT does not reach the response.
        send_req(30'd1);
        load_en = 1'b1; load_addr = 10'd1; load_data = 32'h12345678;
        tick();
        load_en = 1'b0;
        check("wait_wr_instr", rsp_instr, prog[1]);
        consume();

        // Reset in WAIT aborts the fetch.
        send_req(30'd2);
        reset = 1'b1;
        #1;
        check("rstw_ready", 32'(req_ready), 32'd0);
        tick();
        check("rstw_valid", 32'(rsp_valid), 32'd0);
        check("rstw_ready2", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rstw_ready_after", 32'(req_ready), 32'd1);
        tick();
        check("rstw_no_rsp", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface, on the far side of the PC/fetch logic.
- Accepts 30-bit word addresses from the fetch side and returns 32-bit instruction words after a parameterised number of wait states, using a valid/ready handshake.
- Exposes a flush for taken branches and jumps, and a word-wide load port for program preload by the testbench or boot logic.
- Single outstanding request.

Parameters:
- ADDR_WIDTH, 32, byte-address width; the request address is ADDR_WIDTH-2 bits because the lower two bits are always 0.
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two).
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
- BASE_ADDR, 30'h0, word address mapped to storage index 0.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  fetch side presents a word address
- req_addr  input  ADDR_WIDTH-2  word address (PC[31:2])
- req_ready  output  1  responder can accept a request this cycle
- rsp_valid  output  1  rsp_instr/rsp_err are valid
- rsp_ready  input  1  fetch side consumes the response
- rsp_instr  output  32  instruction word
- rsp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS)
- flush  input  1  abandon any pending or held response
- stall  output  1  request in flight or response not yet consumed (feeds the core stall)
- load_en  input  1  preload write strobe
- load_addr  input  log2(DEPTH_WORDS)  preload storage index
- load_data  input  32  preload word

Behaviour:
- Reset: clk and reset as already decided; reset is synchronous, active-high.
  - State goes to IDLE; wait counter to 0.
  - rsp_valid=0, rsp_err=0, rsp_instr=32'h0000_0013 (NOP), stall=0.
  - req_ready=0 while reset is high.
  - Storage contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the address, compute the range check and issue the array read.
  - WAIT_STATES=0 goes to RESP; otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT:
  - req_ready=0, stall=1.
  - Counter decrements each cycle; at 1, go to RESP.
  - Total latency: request accepted at cycle T gives rsp_valid at cycle T+1+WAIT_STATES.
- RESP:
  - rsp_valid=1; rsp_instr and rsp_err stay stable until the handshake.
  - req_ready=rsp_ready.
  - rsp_ready with req_valid: back-to-back accept of the new request, restart latency, next state as in IDLE.
  - rsp_ready without req_valid: go to IDLE, rsp_valid drops next cycle.
  - rsp_ready=0: hold, stall=1.
- stall = (state==WAIT) | (state==RESP & ~rsp_ready) | (state==IDLE & req_valid).
- Out of range (rsp_err=1): rsp_instr=NOP and the storage is not read.
  - Index = req_addr - BASE_ADDR, truncated to log2(DEPTH_WORDS) bits only after the range check.
- Flush (any state):
  - The pending or held response is discarded and rsp_valid=0 next cycle.
  - If req_valid is high in the flush cycle, that request is accepted as if in IDLE (redirect target).
  - Otherwise, go to IDLE.
  - Flush takes priority over rsp_ready.
- Load port:
  - Writes on any cycle, including mid-request.
  - A read and a write to the same index in the same cycle return the OLD data (read-first).
  - A write to the latched index during WAIT is not reflected in the response; data is captured at acceptance.
- Reset mid-WAIT or mid-RESP aborts the transaction with no response.

Decomposition:
- Package eka_imem_pkg:
  - NOP constant 32'h0000_0013.
  - State enum {IDLE, WAIT, RESP}.
  - Wait-counter width constant (4).
- Sub-module imem_ram: single-clock, read-first, one read port plus one write port; parameter DEPTH_WORDS; registered read data.
- imem_responder holds the FSM, range check and response register.

Test Plan:
- Preload index 0..3 with 0x00500093, 0x00108113, 0x002081b3, 0x0000006f; WAIT_STATES=1; request addr 0 at cycle 10 -> rsp_valid at cycle 12, rsp_instr=0x00500093, rsp_err=0, stall high during cycles 10-11.
- rsp_ready held high, req_valid continuous on addrs 1,2,3 -> responses 0x00108113, 0x002081b3, 0x0000006f, each 2 cycles apart, back-to-back accepts.
- Request addr 30'h400 with DEPTH_WORDS=1024, BASE_ADDR=0 -> rsp_err=1, rsp_instr=0x00000013.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_instr and stall stay constant; req_ready=0 throughout.
- Flush in WAIT with req_valid on addr 2 -> the original response never appears; rsp_instr=0x002081b3 two cycles after the flush.
- Same-cycle load_en to index 0 with 0xdeadbeef and request addr 0 -> response 0x00500093; a second request returns 0xdeadbeef.
- Reset asserted in WAIT -> rsp_valid=0, req_ready=0 during reset, req_ready=1 the cycle after reset falls.
